// File: rtl/mem_access_unit.sv
// Load/store unit: alignment check, lane steering, load extension
// and a single-outstanding req/ack bus transaction with timeout.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_mem,
  input  logic [1:0]  W_R_mem,
  input  logic [1:0]  wordsize_mem,
  input  logic        sign_mem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_mem,
  output logic        done_mem,
  output logic        busy_mem,
  output logic        aligned_mem,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [1:0]  ld_size;
  logic [1:0]  ld_off;
  logic        ld_sign;
  logic        start;
  logic        tmo;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;
  logic [31:0] ext;
  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    unique case (wordsize_mem)
      2'b00:   aligned_mem = 1'b1;
      2'b01:   aligned_mem = ~addr[0];
      2'b10:   aligned_mem = (addr[1:0] == 2'b00);
      default: aligned_mem = 1'b0;
    endcase
  end

  assign start = en_mem & aligned_mem &
                 ((W_R_mem == 2'b01) | (W_R_mem == 2'b10));
  assign tmo   = (state == REQ) & ~bus_ack & (cnt == TLAST);

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = wdata;
    unique case (wordsize_mem)
      2'b00: begin
        be_nx    = 4'b0001 << addr[1:0];
        wdata_nx = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_nx    = 4'b0011 << {addr[1], 1'b0};
        wdata_nx = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Extension uses the size/offset latched at start, not live inputs
  always_comb begin
    rb = 8'h00;
    unique case (ld_off)
      2'b00: rb = bus_rdata[7:0];
      2'b01: rb = bus_rdata[15:8];
      2'b10: rb = bus_rdata[23:16];
      2'b11: rb = bus_rdata[31:24];
    endcase
    rh  = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext = bus_rdata;
    unique case (ld_size)
      2'b00:   ext = {{24{ld_sign & rb[7]}}, rb};
      2'b01:   ext = {{16{ld_sign & rh[15]}}, rh};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     if (bus_ack || tmo) state_nx = DONE;
      DONE:    if (!en_mem) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus_req  = (state == REQ);
  assign busy_mem = (state == REQ);
  assign done_mem = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_mem <= '0;
      bus_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ld_size   <= '0;
      ld_off    <= '0;
      ld_sign   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= W_R_mem[1];
            bus_be    <= be_nx;
            bus_wdata <= wdata_nx;
            ld_size   <= wordsize_mem;
            ld_off    <= addr[1:0];
            ld_sign   <= sign_mem;
            bus_err   <= 1'b0;
            cnt       <= '0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) rdata_mem <= ext;
          end else if (tmo) begin
            bus_err   <= 1'b1;
            rdata_mem <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an expected-result
// queue filled at stimulus time and drained on done_mem.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_mem = 1'b0;
  logic [1:0]  W_R_mem = 2'b00;
  logic [1:0]  wordsize_mem = 2'b00;
  logic        sign_mem = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_mem;
  logic        done_mem;
  logic        busy_mem;
  logic        aligned_mem;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .en_mem(en_mem), .W_R_mem(W_R_mem),
    .wordsize_mem(wordsize_mem), .sign_mem(sign_mem), .addr(addr),
    .wdata(wdata), .rdata_mem(rdata_mem), .done_mem(done_mem),
    .busy_mem(busy_mem), .aligned_mem(aligned_mem), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          nreq;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] wr, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int waits);
    exp_t e;
    logic [31:0] sh;
    e.addr = {a[31:2], 2'b00};
    e.we   = (wr == 2'b10);
    sh     = rd >> (8 * a[1:0]);
    case (sz)
      2'b00: begin
        case (a[1:0])
          2'd0: e.be = 4'b0001;
          2'd1: e.be = 4'b0010;
          2'd2: e.be = 4'b0100;
          default: e.be = 4'b1000;
        endcase
        e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        e.rdata = (sg && sh[7]) ? {24'hFFFFFF, sh[7:0]} : {24'h0, sh[7:0]};
      end
      2'b01: begin
        e.be    = a[1] ? 4'b1100 : 4'b0011;
        e.wdata = {wd[15:0], wd[15:0]};
        e.rdata = (sg && sh[15]) ? {16'hFFFF, sh[15:0]} : {16'h0, sh[15:0]};
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = wd;
        e.rdata = rd;
      end
    endcase
    if (e.we) e.rdata = m_rdata;
    e.err  = (waits >= TO);
    e.nreq = (waits >= TO) ? TO : waits + 1;
    if (e.err) e.rdata = 32'h0;
    return e;
  endfunction

  // waits = bus wait states before ack; waits >= TO never acks
  task automatic access(input string tag, input logic [1:0] wr,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits);
    exp_t e;
    int   n;
    bit   got;
    q.push_back(model(wr, sz, sg, a, wd, rd, waits));
    @(negedge clk);
    en_mem = 1'b1; W_R_mem = wr; wordsize_mem = sz; sign_mem = sg;
    addr = a; wdata = wd; bus_ack = 1'b0; bus_rdata = rd;
    #1 chk({tag, " aligned"}, 32'(aligned_mem), 32'd1);
    n = 0;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        if (n == 0) begin
          chk({tag, " bus_addr"}, bus_addr, q[0].addr);
          chk({tag, " bus_we"}, 32'(bus_we), 32'(q[0].we));
          chk({tag, " bus_be"}, 32'(bus_be), 32'(q[0].be));
          if (q[0].we) chk({tag, " bus_wdata"}, bus_wdata, q[0].wdata);
        end
        n++;
        bus_ack = (n - 1 == waits);
      end else begin
        bus_ack = 1'b0;
      end
      if (done_mem) got = 1;
    end
    chk({tag, " done"}, 32'(got), 32'd1);
    if (got) begin
      e = q.pop_front();
      chk({tag, " req_cycles"}, 32'(n), 32'(e.nreq));
      chk({tag, " rdata"}, rdata_mem, e.rdata);
      chk({tag, " bus_err"}, 32'(bus_err), 32'(e.err));
      m_rdata = e.rdata;
      @(posedge clk); #1;
      chk({tag, " done_held"}, 32'(done_mem), 32'd1);
    end else begin
      q.delete();
    end
    en_mem = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done_drop"}, 32'(done_mem), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst rdata", rdata_mem, 32'h0);
    chk("rst outs", {26'h0, done_mem, busy_mem, bus_err, bus_req, bus_we,
        |bus_be}, 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    @(negedge clk) reset = 1'b0;

    access("st_word", 2'b10, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 1);
    access("ld_byte_s", 2'b01, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF1234, 0);
    access("ld_byte_u", 2'b01, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF1234, 0);
    access("ld_half_u", 2'b01, 2'b01, 1'b0, 32'h12, 32'h0, 32'hA55A0000, 2);
    access("st_half", 2'b10, 2'b01, 1'b0, 32'h12, 32'h1234, 32'h0, 0);
    access("ld_half_s", 2'b01, 2'b01, 1'b1, 32'h40, 32'h0, 32'h00058001, 0);
    access("st_byte1", 2'b10, 2'b00, 1'b0, 32'h81, 32'h77AB, 32'h0, 1);

    // Misaligned commands never reach the bus
    @(negedge clk);
    en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b10; addr = 32'h102;
    #1 chk("mis word aligned", 32'(aligned_mem), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("mis idle", {30'h0, bus_req, done_mem}, 32'h0);
    end
    wordsize_mem = 2'b01; addr = 32'h101;
    #1 chk("mis half aligned", 32'(aligned_mem), 32'd0);
    wordsize_mem = 2'b11; addr = 32'h100;
    #1 chk("rsvd size aligned", 32'(aligned_mem), 32'd0);
    en_mem = 1'b0;

    access("timeout", 2'b01, 2'b10, 1'b0, 32'h300, 32'h0, 32'h1111, 99);
    access("ack_last", 2'b01, 2'b10, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, 3);

    // Reset during the second REQ cycle of a wait-stated load
    @(negedge clk);
    en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b10; addr = 32'h400;
    bus_ack = 1'b0; bus_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    chk("rstreq req1", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    chk("rstreq req2", 32'(bus_req), 32'd1);
    reset = 1'b1; bus_ack = 1'b1;
    @(posedge clk); #1;
    chk("rstreq after", {29'h0, bus_req, done_mem, busy_mem}, 32'h0);
    reset = 1'b0; en_mem = 1'b0;
    @(posedge clk); #1;
    chk("rstreq late_ack", {30'h0, bus_req, done_mem}, 32'h0);
    chk("rstreq rdata", rdata_mem, 32'h0);
    bus_ack = 1'b0;
    m_rdata = 32'h0;

    access("post_rst", 2'b01, 2'b10, 1'b0, 32'h408, 32'h0, 32'h13572468, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
